// File: rtl/inv_mix_columns.sv
// -----------------------------------------------------------------------------
// inv_mix_columns
//
// Purpose: AES InvMixColumns on a 128-bit state. The state is captured on
// acceptance and then transformed COLS_PER_CYCLE columns per clock. The
// finished result is held on data_out until downstream takes it.
// Sequence: IDLE (accept) -> CALC (N = 4/COLS_PER_CYCLE cycles) -> HOLD -> IDLE.
//
// Parameters:
//   COLS_PER_CYCLE   columns transformed per clock: 1, 2 or 4
//
// Ports:
//   clk        clock, all state on the rising edge
//   rst        synchronous reset, active low
//   in_valid   data_in holds a state to accept
//   in_ready   high only while idle
//   data_in    AES state: byte i = data_in[127-8i -: 8], column c = bytes 4c..4c+3
//   bypass     (only with INV_MIX_COLUMNS_BYPASS_EN) pass the state through
//              unchanged, captured together with data_in
//   out_valid  data_out holds a finished result
//   out_ready  downstream takes data_out
//   data_out   result, same byte/column ordering as data_in
//
// Optional feature macro: INV_MIX_COLUMNS_BYPASS_EN adds the bypass input.
// -----------------------------------------------------------------------------
module inv_mix_columns #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
`ifdef INV_MIX_COLUMNS_BYPASS_EN
    input  logic         bypass,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out
);

    localparam int         N_STEPS   = 4 / COLS_PER_CYCLE;
    localparam int         COL_SHIFT = (COLS_PER_CYCLE == 4) ? 2 : ((COLS_PER_CYCLE == 2) ? 1 : 0);
    localparam logic [1:0] LAST_STEP = 2'(N_STEPS - 1);

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
            $error("inv_mix_columns: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    // Doubling in GF(2^8); the reduction depends only on the byte being doubled.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a  [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int k = 0; k < 4; k++) begin
            a[k]  = col[31-8*k -: 8];
            x2[k] = xtime(a[k]);
            x4[k] = xtime(x2[k]);
            x8[k] = xtime(x4[k]);
            m9[k] = x8[k] ^ a[k];
            mb[k] = x8[k] ^ x2[k] ^ a[k];
            md[k] = x8[k] ^ x4[k] ^ a[k];
            me[k] = x8[k] ^ x4[k] ^ x2[k];
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_HOLD
    } state_t;

    state_t       r_state;
    logic         r_in_ready;
    logic         r_out_valid;
    logic [1:0]   r_col;
    logic [127:0] r_in;
    logic [127:0] r_out;
`ifdef INV_MIX_COLUMNS_BYPASS_EN
    logic         r_bypass;
`endif

    logic [31:0]  w_in_cols [4];
    logic [1:0]   w_base;
    logic [1:0]   w_idx [COLS_PER_CYCLE];
    logic [31:0]  w_res [COLS_PER_CYCLE];
    logic [31:0]  w_out_cols [4];
    logic [127:0] w_out_next;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_unpack
            assign w_in_cols[gi] = r_in[127-32*gi -: 32];
        end
    endgenerate

    // First column of this cycle's group; N_STEPS*COLS_PER_CYCLE = 4 keeps it in 0..3.
    assign w_base = r_col << COL_SHIFT;

    generate
        for (gi = 0; gi < COLS_PER_CYCLE; gi++) begin : g_lane
            assign w_idx[gi] = w_base + 2'(gi);
`ifdef INV_MIX_COLUMNS_BYPASS_EN
            assign w_res[gi] = r_bypass ? w_in_cols[w_idx[gi]]
                                        : inv_mix_col(w_in_cols[w_idx[gi]]);
`else
            assign w_res[gi] = inv_mix_col(w_in_cols[w_idx[gi]]);
`endif
        end
    endgenerate

    // Overwrite only this cycle's columns; the rest keep their previous value.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_out_cols[k] = r_out[127-32*k -: 32];
        end
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
            w_out_cols[w_idx[j]] = w_res[j];
        end
        w_out_next = {w_out_cols[0], w_out_cols[1], w_out_cols[2], w_out_cols[3]};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_col       <= 2'd0;
            r_in        <= '0;
            r_out       <= '0;
`ifdef INV_MIX_COLUMNS_BYPASS_EN
            r_bypass    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_in       <= data_in;
`ifdef INV_MIX_COLUMNS_BYPASS_EN
                        r_bypass   <= bypass;
`endif
                        r_col      <= 2'd0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_out <= w_out_next;
                    if (r_col == LAST_STEP) begin
                        r_col       <= 2'd0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_HOLD;
                    end else begin
                        r_col <= r_col + 2'd1;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_col       <= 2'd0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign data_out  = r_out;

endmodule

// File: tb/tb_inv_mix_columns.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_inv_mix_columns
//
// Self-checking bench for inv_mix_columns. A cycle-level reference model
// (generic GF(2^8) shift-and-add multiply, matrix form of InvMixColumns, and a
// timeline of accept / result / handoff events) is checked against in_ready,
// out_valid and data_out on every cycle. Directed vectors pin the model to
// known AES values; randomized traffic covers stalls, resets and data churn.
// -----------------------------------------------------------------------------
module tb_inv_mix_columns;

    localparam int COLS = 1;
    localparam int N    = 4 / COLS;

    logic         clk       = 1'b0;
    logic         rst       = 1'b0;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [127:0] data_in   = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] data_out;
    logic         tb_bypass = 1'b0;

    always #5 clk = ~clk;

    inv_mix_columns #(
        .COLS_PER_CYCLE(COLS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .data_in  (data_in),
`ifdef INV_MIX_COLUMNS_BYPASS_EN
        .bypass   (tb_bypass),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .data_out (data_out)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference arithmetic ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_imc(input logic [127:0] s);
        int           coef [4][4];
        logic [127:0] r;
        logic [7:0]   acc;
        coef = '{'{14, 11, 13, 9}, '{9, 14, 11, 13}, '{13, 9, 14, 11}, '{11, 13, 9, 14}};
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) begin
                    acc = acc ^ gmul(s[127-8*(4*c+k) -: 8], 8'(coef[row][k]));
                end
                r[127-8*(4*c+row) -: 8] = acc;
            end
        end
        return r;
    endfunction

    // ---------------- model + per-cycle compare ----------------
    logic         m_busy   = 1'b0;
    int           m_accept = 0;
    int           cyc      = 0;
    logic [127:0] m_exp    = '0;
    logic [127:0] m_last   = '0;
    logic         exp_valid;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst) begin
                m_busy = 1'b0;
                m_last = '0;
            end else if (!m_busy) begin
                if (in_valid) begin
                    m_busy   = 1'b1;
                    m_accept = cyc;
                    m_exp    = tb_bypass ? data_in : ref_imc(data_in);
                end
            end else if ((cyc - m_accept >= N + 1) && out_ready) begin
                m_busy = 1'b0;
                m_last = m_exp;
            end
            @(negedge clk);
            // Result is first seen on the (N+1)-th edge after acceptance.
            exp_valid = m_busy && (cyc + 1 - m_accept >= N + 1);
            check("cyc_in_ready", in_ready, !m_busy);
            check("cyc_out_valid", out_valid, exp_valid);
            if (exp_valid)
                check("cyc_data_out_hold", data_out, m_exp);
            else if (!m_busy)
                check("cyc_data_out_idle", data_out, m_last);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic run_op(input string nm, input logic [127:0] d, input logic byp,
                          input logic [127:0] lit);
        int lat;
        check({nm, "_ready_before"}, in_ready, 1'b1);
        data_in   = d;
        tb_bypass = byp;
        in_valid  = 1'b1;
        step();
        in_valid  = 1'b0;
        data_in   = rand128();
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            data_in = rand128();
            lat++;
        end
        // out_valid rises after edge N, i.e. it is sampled high on edge N+1.
        check({nm, "_latency"}, lat, N);
        check({nm, "_data"}, data_out, lit);
        tb_bypass = 1'b0;
    endtask

    int           acc;
    int           last_acc;
    int           cnt;
    logic         pre_ready;
    logic [127:0] held;
    logic [127:0] d;

    initial begin
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();
        rst = 1'b1;
        check("reset_data_out", data_out, 128'h0);
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_out_valid", out_valid, 1'b0);

        // Known vectors also pin the model.
        check("model_pin_a", ref_imc({4{32'h8e4da1bc}}), {4{32'hdb135345}});
        check("model_pin_b", ref_imc(128'h9fdc589d_01010101_c6c6c6c6_8e4da1bc),
              128'hf20a225c_01010101_c6c6c6c6_db135345);

        run_op("vec_a", {4{32'h8e4da1bc}}, 1'b0, {4{32'hdb135345}});
        step();
        check("vec_a_done_valid", out_valid, 1'b0);
        check("vec_a_done_ready", in_ready, 1'b1);

        run_op("vec_b", 128'h9fdc589d_01010101_c6c6c6c6_8e4da1bc, 1'b0,
               128'hf20a225c_01010101_c6c6c6c6_db135345);
        step();

        // Stall in HOLD for 10 cycles while in_valid/data_in churn.
        out_ready = 1'b0;
        d = rand128();
        run_op("stall", d, 1'b0, ref_imc(d));
        held = data_out;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            data_in  = rand128();
            step();
            check("stall_valid", out_valid, 1'b1);
            check("stall_data", data_out, held);
            check("stall_in_ready", in_ready, 1'b0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("stall_release_valid", out_valid, 1'b0);
        check("stall_release_ready", in_ready, 1'b1);

        // Reset during the first CALC cycle discards the operation.
        data_in  = rand128();
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("abort_valid", out_valid, 1'b0);
        check("abort_ready", in_ready, 1'b1);
        check("abort_data", data_out, 128'h0);
        for (int i = 0; i < 2 * N + 4; i++) begin
            step();
            check("abort_no_stale", out_valid, 1'b0);
        end

`ifdef INV_MIX_COLUMNS_BYPASS_EN
        run_op("bypass", 128'h00112233445566778899aabbccddeeff, 1'b1,
               128'h00112233445566778899aabbccddeeff);
        step();
`endif

        // Back-to-back: one acceptance every N+2 cycles.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        acc       = 0;
        last_acc  = 0;
        cnt       = 0;
        while (acc < 1000 && cnt < 1000 * (N + 2) + 50) begin
            data_in   = rand128();
            pre_ready = in_ready;
            step();
            cnt++;
            if (pre_ready) begin
                if (acc > 0) check("throughput_gap", cnt - last_acc, N + 2);
                last_acc = cnt;
                acc++;
            end
        end
        check("b2b_accepts", acc, 1000);
        in_valid = 1'b0;
        repeat (N + 3) step();

        // Random traffic with stalls and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(1, 0) == 1);
            out_ready = ($urandom_range(3, 0) != 0);
            data_in   = rand128();
            rst       = ($urandom_range(299, 0) != 0);
`ifdef INV_MIX_COLUMNS_BYPASS_EN
            tb_bypass = ($urandom_range(3, 0) == 0);
`endif
            step();
        end
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tb_bypass = 1'b0;
        repeat (N + 4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/inv_mix_columns.md
INV_MIX_COLUMNS -- requirements
Module: inv_mix_columns

Interface
REQ-001 SHALL have parameter COLS_PER_CYCLE, default 1, giving the columns processed per cycle; legal values are 1, 2 and 4.
REQ-002 SHALL have port clk, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: the input state is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the block can accept a state.
REQ-006 SHALL have port data_in, input, 128 bits: the AES state. Byte i = data_in[127-8i -: 8]; column c = bytes 4c..4c+3, with byte 4c in row 0.
REQ-007 SHALL have port out_valid, output, 1 bit: data_out is valid.
REQ-008 SHALL have port out_ready, input, 1 bit: downstream accepts data_out.
REQ-009 SHALL have port data_out, output, 128 bits: the result, using the same byte and column ordering as data_in.

Function
REQ-010 SHALL compute AES InvMixColumns per column (a0..a3 to b0..b3):
- b0 = 0e*a0 ^ 0b*a1 ^ 0d*a2 ^ 09*a3
- b1 = 09*a0 ^ 0e*a1 ^ 0b*a2 ^ 0d*a3
- b2 = 0d*a0 ^ 09*a1 ^ 0e*a2 ^ 0b*a3
- b3 = 0b*a0 ^ 0d*a1 ^ 09*a2 ^ 0e*a3
REQ-011 SHALL perform GF(2^8) multiplication with xtime chains modulo 0x11b.
- Each xtime step SHALL reduce by 0x1b based on the MSB of the byte being doubled, not of any other byte.
- All intermediate values SHALL be 8 bits wide.
REQ-012 SHALL implement the state machine IDLE -> CALC -> HOLD -> IDLE.
REQ-013 IDLE SHALL drive in_ready=1 and out_valid=0. On a clock edge with in_valid=1, the block SHALL register data_in, clear the column counter and enter CALC.
REQ-014 CALC SHALL drive in_ready=0 and out_valid=0.
- Each cycle it SHALL transform COLS_PER_CYCLE columns into the result register, starting at column 0.
- It SHALL enter HOLD after N = 4/COLS_PER_CYCLE cycles.
- Columns not yet written SHALL hold their previous values.
REQ-015 Latency: out_valid SHALL rise exactly N+1 cycles after the accepting edge (2, 3 or 5 cycles for COLS_PER_CYCLE = 4, 2 or 1).
REQ-016 HOLD SHALL drive out_valid=1 with data_out stable.
- When out_ready=1, it SHALL return to IDLE on that edge.
- While out_ready=0, it SHALL stay in HOLD indefinitely with data_out unchanged.
REQ-017 in_ready SHALL be 1 only in IDLE. in_valid in CALC or HOLD SHALL be ignored, and data_in changes in those states SHALL NOT affect the result.
REQ-018 Throughput: one state per N+2 cycles when out_ready is held at 1.
REQ-019 The column counter SHALL wrap from N-1 to 0 only when leaving CALC, and SHALL never index past column 3.
REQ-020 COLS_PER_CYCLE values other than 1, 2 or 4 SHALL cause an elaboration error.

Reset
REQ-021 With rst=0 at a clock edge, the block SHALL enter IDLE with in_ready=1, out_valid=0, data_out=128'h0 and the counter at 0.
REQ-022 Reset SHALL take priority over every event, including in_valid acceptance and out_ready completion.
REQ-023 Reset during CALC or HOLD SHALL abort the operation and produce no output, and the state being processed SHALL be discarded.

Configuration
REQ-024 Macro INV_MIX_COLUMNS_BYPASS_EN.
- When defined, the block SHALL add input port bypass (1 bit), sampled with data_in on acceptance.
- With bypass=1, the result SHALL equal data_in unchanged, with identical latency and handshake; this serves the final AES decryption round.
- When undefined, the port SHALL be absent and the transform SHALL always be applied.

Verification
REQ-025 Column 8e4da1bc repeated in all four columns, in_valid pulse -> data_out = db135345 x4, out_valid after N+1 cycles.
REQ-026 data_in = 9fdc589d_01010101_c6c6c6c6_8e4da1bc -> data_out = f20a225c_01010101_c6c6c6c6_db135345.
REQ-027 out_ready held at 0 for 10 cycles in HOLD -> out_valid stays 1, data_out stable, in_ready stays 0; out_ready=1 -> IDLE on the next edge.
REQ-028 rst=0 asserted during CALC cycle 1 (COLS_PER_CYCLE=1) -> next cycle IDLE, out_valid=0, data_out=0, and no stale output later.
REQ-029 Back-to-back in_valid=1 with out_ready=1 -> accepts exactly one state per N+2 cycles, and results match the software model for 1000 random states.
REQ-030 INV_MIX_COLUMNS_BYPASS_EN defined, bypass=1, data_in=00112233445566778899aabbccddeeff -> same value out after N+1 cycles.
